// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch front end.
package if_pkg;

  // Widths of the fetch entry fields. The top's AW/IW must match these.
  localparam int FETCH_AW = 32;
  localparam int FETCH_IW = 32;

  // Instruction presented when nothing valid is available.
  localparam logic [FETCH_IW-1:0] NOP_INSTR = '0;

  // Sequential fetch stride in bytes.
  localparam int unsigned PC_STEP = 4;

  // One prefetched instruction together with the address it came from.
  typedef struct packed {
    logic [FETCH_AW-1:0] pc;
    logic [FETCH_IW-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fifo.sv
// Synchronous prefetch FIFO; clear wins over push and pop in the same cycle.
module if_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clear,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty && !clear;
  assign do_push = push && (!full || do_pop) && !clear;
  assign dout    = mem[rd_ptr];

  // Entry storage: written on push only.
  // NOTE: the data array is deliberately not reset; count/empty gate every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointer and occupancy bookkeeping.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (!do_push && do_pop) count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch front end: PC, credit-based read issue, in-order response
// capture into a prefetch queue, and redirect with flush of in-flight reads.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int            IW       = FETCH_IW,
  parameter int            AW       = FETCH_AW,
  parameter int            DEPTH    = 4,
  parameter logic [AW-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  input  logic          stall,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc,
  output logic [IW-1:0] ir,
  output logic          ir_valid,
  output logic [AW-1:0] pc_out
);

  localparam int            CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]   CREDITS = (CW+1)'(DEPTH);

  logic [AW-1:0] pc_q;
  logic [AW-1:0] rsp_pc_q;     // address of the next response that will be kept
  logic [CW-1:0] inflight_q;
  logic [CW-1:0] inflight_d;
  logic [CW-1:0] discard_q;
  logic [CW-1:0] fifo_count;
  logic [CW:0]   occupancy;
  logic          fifo_full;
  logic          fifo_empty;
  logic          issue;
  logic          rsp_ok;
  logic          push;
  logic          pop;
  fetch_entry_t  push_entry;
  fetch_entry_t  head_entry;

  // Reads already requested plus words already queued may never exceed the queue size.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifo_count};
  assign issue     = rst_n && !redirect && (occupancy < CREDITS);

  // A response with nothing outstanding is a protocol error and is ignored.
  assign rsp_ok = imem_rvalid && (inflight_q != '0);

  // The full guard cannot trigger under the credit rule; it keeps the queue from ever seeing a rejected push.
  assign push       = rsp_ok && (discard_q == '0) && !redirect && (!fifo_full || pop);
  assign pop        = ir_valid && !stall && !redirect;
  assign push_entry = '{pc: rsp_pc_q, instr: imem_rdata};

  assign imem_req  = issue;
  assign imem_addr = pc_q;
  assign ir_valid  = !fifo_empty;
  assign ir        = ir_valid ? head_entry.instr : NOP_INSTR;
  assign pc_out    = ir_valid ? head_entry.pc    : '0;

  // Outstanding-read count after this cycle's issue and response.
  // NOTE: give every always_comb output a default first so no path can infer a latch.
  always_comb begin
    inflight_d = inflight_q;
    if (issue && !rsp_ok)      inflight_d = inflight_q + CW'(1);
    else if (!issue && rsp_ok) inflight_d = inflight_q - CW'(1);
  end

  // PC, response address and in-flight/discard counters; redirect overrides everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      discard_q  <= '0;
    end else begin
      inflight_q <= inflight_d;
      if (redirect) begin
        pc_q      <= redirect_pc;
        rsp_pc_q  <= redirect_pc;
        discard_q <= inflight_d;
      end else begin
        if (issue) pc_q <= pc_q + AW'(PC_STEP);
        if (rsp_ok) begin
          if (discard_q != '0) discard_q <= discard_q - CW'(1);
          else                 rsp_pc_q  <= rsp_pc_q + AW'(PC_STEP);
        end
      end
    end
  end

  if_fifo #(
    .W     ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (redirect),
    .push  (push),
    .pop   (pop),
    .din   (push_entry),
    .dout  (head_entry),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: table-driven per-cycle vectors plus
// hand-written sequences for reset with a full queue and redirect on slow memory.
module tb_if_fetch_unit;

  localparam logic [31:0] K = 32'hA5A5_0000;

  typedef struct {
    logic        stall;
    logic        redirect;
    logic [31:0] rpc;
    logic        req;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  int          lat = 1;
  int          n_tests = 0;
  int          n_fail = 0;

  // Main DUT (RESET_PC = 0)
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] pc_out;

  // Second DUT with a PC that wraps
  logic        req2;
  logic [31:0] addr2;
  logic        rvalid2;
  logic [31:0] rdata2;
  logic        stall2 = 1'b0;
  logic        redirect2 = 1'b0;
  logic [31:0] redirect_pc2 = '0;
  logic [31:0] ir2;
  logic        ir_valid2;
  logic [31:0] pc_out2;

  always #5 clk = ~clk;

  if_fetch_unit #(.IW(32), .AW(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
    .ir(ir), .ir_valid(ir_valid), .pc_out(pc_out)
  );

  if_fetch_unit #(.IW(32), .AW(32), .DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) dut2 (
    .clk(clk), .rst_n(rst_n),
    .imem_req(req2), .imem_addr(addr2),
    .imem_rvalid(rvalid2), .imem_rdata(rdata2),
    .stall(stall2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .ir(ir2), .ir_valid(ir_valid2), .pc_out(pc_out2)
  );

  // Fixed-latency memory models: a delay line of requests; data = addr ^ K.
  logic [3:0]  p1_v;
  logic [31:0] p1_a [4];
  logic [3:0]  p2_v;
  logic [31:0] p2_a [4];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= '0;
    end else begin
      p1_v    <= {p1_v[2:0], imem_req};
      p1_a[0] <= imem_addr;
      for (int k = 1; k < 4; k++) p1_a[k] <= p1_a[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p2_v <= '0;
    end else begin
      p2_v    <= {p2_v[2:0], req2};
      p2_a[0] <= addr2;
      for (int k = 1; k < 4; k++) p2_a[k] <= p2_a[k-1];
    end
  end

  assign imem_rvalid = p1_v[lat-1];
  assign imem_rdata  = p1_a[lat-1] ^ K;
  assign rvalid2     = p2_v[0];
  assign rdata2      = p2_a[0] ^ K;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic st, input logic rd, input logic [31:0] rpc,
                              input logic rq, input logic [31:0] ad,
                              input logic vl, input logic [31:0] pc);
    vec_t v;
    v.stall = st; v.redirect = rd; v.rpc = rpc;
    v.req = rq; v.addr = ad; v.valid = vl; v.pc = pc;
    return v;
  endfunction

  // Drive one cycle's inputs, let them settle, compare all main-DUT outputs.
  task automatic run_vec(input string tag, input vec_t v);
    stall       = v.stall;
    redirect    = v.redirect;
    redirect_pc = v.rpc;
    #1;
    check({tag, " req"}, 32'(imem_req), 32'(v.req));
    if (v.req) check({tag, " addr"}, imem_addr, v.addr);
    check({tag, " valid"}, 32'(ir_valid), 32'(v.valid));
    check({tag, " pc_out"}, pc_out, v.valid ? v.pc : 32'h0);
    check({tag, " ir"}, ir, v.valid ? (v.pc ^ K) : 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req"}, 32'(imem_req), 32'h0);
    check({tag, " addr"}, imem_addr, 32'h0);
    check({tag, " ir"}, ir, 32'h0);
    check({tag, " valid"}, 32'(ir_valid), 32'h0);
    check({tag, " pc_out"}, pc_out, 32'h0);
    check({tag, " dut2 addr"}, addr2, 32'hFFFF_FFF8);
    check({tag, " dut2 req"}, 32'(req2), 32'h0);
  endtask

  vec_t        tbl [24];
  vec_t        seq [10];
  logic [31:0] exp2 [4];

  initial begin
    // Cycle-by-cycle table with 1-cycle memory: stream, 6-cycle stall, redirect.
    tbl[0]  = mk(0, 0, 0,      1, 32'h00,  0, 0);
    tbl[1]  = mk(0, 0, 0,      1, 32'h04,  0, 0);
    tbl[2]  = mk(0, 0, 0,      1, 32'h08,  1, 32'h00);
    tbl[3]  = mk(0, 0, 0,      1, 32'h0C,  1, 32'h04);
    tbl[4]  = mk(0, 0, 0,      1, 32'h10,  1, 32'h08);
    tbl[5]  = mk(0, 0, 0,      1, 32'h14,  1, 32'h0C);
    tbl[6]  = mk(0, 0, 0,      1, 32'h18,  1, 32'h10);
    tbl[7]  = mk(0, 0, 0,      1, 32'h1C,  1, 32'h14);
    tbl[8]  = mk(1, 0, 0,      1, 32'h20,  1, 32'h18);
    tbl[9]  = mk(1, 0, 0,      1, 32'h24,  1, 32'h18);
    tbl[10] = mk(1, 0, 0,      0, 32'h28,  1, 32'h18);
    tbl[11] = mk(1, 0, 0,      0, 32'h28,  1, 32'h18);
    tbl[12] = mk(1, 0, 0,      0, 32'h28,  1, 32'h18);
    tbl[13] = mk(1, 0, 0,      0, 32'h28,  1, 32'h18);
    tbl[14] = mk(0, 0, 0,      0, 32'h28,  1, 32'h18);
    tbl[15] = mk(0, 0, 0,      1, 32'h28,  1, 32'h1C);
    tbl[16] = mk(0, 0, 0,      1, 32'h2C,  1, 32'h20);
    tbl[17] = mk(0, 0, 0,      1, 32'h30,  1, 32'h24);
    tbl[18] = mk(0, 0, 0,      1, 32'h34,  1, 32'h28);
    tbl[19] = mk(0, 0, 0,      1, 32'h38,  1, 32'h2C);
    tbl[20] = mk(1, 1, 32'h200, 0, 32'h0,  1, 32'h30);
    tbl[21] = mk(0, 0, 0,      1, 32'h200, 0, 0);
    tbl[22] = mk(0, 0, 0,      1, 32'h204, 0, 0);
    tbl[23] = mk(0, 0, 0,      1, 32'h208, 1, 32'h200);

    // 3-cycle memory: redirect with 3 in flight while the oldest response arrives.
    seq[0] = mk(0, 0, 0,       1, 32'h000, 0, 0);
    seq[1] = mk(0, 0, 0,       1, 32'h004, 0, 0);
    seq[2] = mk(0, 0, 0,       1, 32'h008, 0, 0);
    seq[3] = mk(1, 1, 32'h100, 0, 32'h0,   0, 0);
    seq[4] = mk(0, 0, 0,       1, 32'h100, 0, 0);
    seq[5] = mk(0, 0, 0,       1, 32'h104, 0, 0);
    seq[6] = mk(0, 0, 0,       1, 32'h108, 0, 0);
    seq[7] = mk(0, 0, 0,       1, 32'h10C, 0, 0);
    seq[8] = mk(0, 0, 0,       0, 32'h0,   1, 32'h100);
    seq[9] = mk(0, 0, 0,       1, 32'h110, 1, 32'h104);

    exp2[0] = 32'hFFFF_FFF8;
    exp2[1] = 32'hFFFF_FFFC;
    exp2[2] = 32'h0000_0000;
    exp2[3] = 32'h0000_0004;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_reset_outputs("reset");

    // Release reset at a falling edge; the next rising edge is cycle 0.
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      run_vec($sformatf("A%0d", i), tbl[i]);
      if (i == 0) begin
        check("A0 dut2 req", 32'(req2), 32'h1);
        check("A0 dut2 addr", addr2, 32'hFFFF_FFF8);
      end
      if (i >= 2 && i <= 5) begin
        check($sformatf("A%0d dut2 valid", i), 32'(ir_valid2), 32'h1);
        check($sformatf("A%0d dut2 pc_out", i), pc_out2, exp2[i-2]);
        check($sformatf("A%0d dut2 ir", i), ir2, exp2[i-2] ^ K);
      end
      @(negedge clk);
    end

    // Stall until the queue is full, then reset mid-operation.
    stall    = 1'b1;
    redirect = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check("full req", 32'(imem_req), 32'h0);
    check("full valid", 32'(ir_valid), 32'h1);
    check("full pc_out", pc_out, 32'h204);
    check("full ir", ir, 32'h204 ^ K);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midreset");
    stall = 1'b0;
    lat   = 3;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Restart from RESET_PC on 3-cycle memory and redirect with reads in flight.
    for (int i = 0; i < 10; i++) begin
      run_vec($sformatf("C%0d", i), seq[i]);
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/if_fetch_unit.md
# if_fetch_unit

Instruction fetch front end that drives the pipeline's `ir` input: keeps the program counter, issues in-order reads to instruction memory, buffers returned words in a small prefetch queue, and presents one instruction per cycle with its PC. When no valid instruction is available it presents NOP (`32'h0000_0000`). It absorbs pipeline stalls and supports branch redirect with flush of queued and in-flight fetches.

## Interface
- `IW`, 32, instruction width
- `AW`, 32, address/PC width
- `DEPTH`, 4, prefetch entries; power of two, ≥2
- `RESET_PC`, 0, first fetch address after reset

- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `imem_req`  out  1  read request this cycle
- `imem_addr`  out  AW  read address, valid with `imem_req`
- `imem_rvalid`  in  1  read data valid; responses return in request order, latency ≥1
- `imem_rdata`  in  IW  read data
- `stall`  in  1  pipeline not accepting `ir` this cycle
- `redirect`  in  1  branch/jump taken; restart fetch at `redirect_pc`
- `redirect_pc`  in  AW  new fetch address
- `ir`  out  IW  instruction to pipeline; 0 when `ir_valid`=0
- `ir_valid`  out  1  `ir`/`pc_out` hold a real instruction
- `pc_out`  out  AW  PC of `ir`; 0 when `ir_valid`=0

## Operation
- Reset: `pc`=RESET_PC, queue empty, `inflight`=0, `discard`=0; outputs `imem_req`=0, `imem_addr`=RESET_PC, `ir`=0, `ir_valid`=0, `pc_out`=0.
- Issue: `imem_req`=1 when `redirect`=0 and `inflight + count < DEPTH` (credit rule; queue never overflows). On issue `imem_addr`=`pc`, `pc` += 4 (modulo 2^AW, wraps silently).
- `inflight` +1 on issue, −1 on `imem_rvalid`; both same cycle → unchanged.
- Response: if `discard`>0, drop and decrement `discard`; else push {addr, rdata} into queue (addr = PC the word was fetched from).
- Present: head of queue drives `ir`/`pc_out`, `ir_valid`=!empty. Pop when `ir_valid`=1 and `stall`=0. While stalled, outputs hold.
- Redirect (priority over everything): queue cleared, `pc`←`redirect_pc`, no request that cycle, `discard`←`inflight` after this cycle's update (a response arriving in the redirect cycle is itself dropped and counted). Next cycle issues from `redirect_pc`. `stall` ignored in redirect cycle.
- `imem_rvalid` with `inflight`=0 is a protocol error: ignored, counters unchanged.
- Reset mid-operation: all state returns to reset values immediately; stale memory responses after reset are the memory's responsibility to suppress.

## Timing
- With 1-cycle memory: request in cycle N, `imem_rvalid` in N+1, `ir_valid` in N+2. First request is the first clock edge with `rst_n`=1.
- Steady state without stalls: one instruction per cycle, PCs consecutive by 4.
- Redirect in cycle R: `ir_valid`=0 in R+1; with 1-cycle memory first redirected instruction presented in R+3.
- Queue push/pop same cycle when full or empty: legal; count unchanged (full) or pass-through after one cycle (empty; no combinational bypass from `imem_rdata` to `ir`).

## Structure
- Package `if_pkg`: `NOP_INSTR`=0, `PC_STEP`=4, fetch entry struct {pc, instr}.
- Sub-module `if_fifo`: synchronous DEPTH×(AW+IW) FIFO with push, pop, clear, count, full/empty; clear has priority over push/pop.
- Top holds PC, `inflight`/`discard` counters and issue logic.

## Test plan
- Reset, 1-cycle memory returning `addr ^ 32'hA5A5_0000`, no stall → `ir_valid` from cycle 2, `pc_out` 0,4,8,…, `ir` matches data, one per cycle.
- Hold `stall`=1 for 6 cycles → `ir`/`pc_out` frozen; `imem_req` drops after 4 outstanding+queued; on release, no instruction lost or duplicated.
- `redirect`=1, `redirect_pc`=32'h100 with 3 in flight on 3-cycle memory → 3 responses dropped, next `pc_out`=32'h100, then 32'h104.
- Redirect same cycle as `imem_rvalid` → that word never reaches `ir`; `discard` correct.
- `RESET_PC`=32'hFFFF_FFF8 → PCs FFFF_FFF8, FFFF_FFFC, 0000_0000, 0000_0004.
- Assert `rst_n`=0 with queue full → all outputs at reset values same cycle; restart from RESET_PC.
